// File: rtl/src_shift_reg_pkg.sv
// Shared definitions for the wavefront-to-ALU source serializer.
// Lane geometry, derived vector widths and the FSM state type.
package src_shift_reg_pkg;

  localparam int unsigned WF_LANES   = 64;
  localparam int unsigned ALU_LANES  = 16;
  localparam int unsigned NUM_BEATS  = WF_LANES / ALU_LANES;
  localparam int unsigned WF_VEC_W   = WF_LANES * 32;
  localparam int unsigned BEAT_VEC_W = ALU_LANES * 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/src_shift_reg_shift_in.sv
// Loadable 64-lane register that shifts right by one 16-lane slice per
// beat and presents its low slice.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load_en    - capture load_data (has priority over shift_en)
//   load_data  - full wavefront value, lane i at [LANE_WIDTH*i +: LANE_WIDTH]
//   shift_en   - drop the low slice, zeros enter at the top
//   beat_data  - low 16 lanes of the register
module src_shift_reg_shift_in
  import src_shift_reg_pkg::*;
#(
  parameter int unsigned LANE_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_en,
  input  logic [WF_LANES*LANE_WIDTH-1:0]  load_data,
  input  logic                            shift_en,
  output logic [ALU_LANES*LANE_WIDTH-1:0] beat_data
);

  localparam int unsigned SLICE_W = ALU_LANES * LANE_WIDTH;

  logic [WF_LANES*LANE_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_en) begin
      data_q <= load_data;
    end else if (shift_en) begin
      data_q <= data_q >> SLICE_W;
    end
  end

  assign beat_data = data_q[SLICE_W-1:0];

endmodule

// File: rtl/src_shift_reg.sv
// Wavefront-to-ALU source serializer. Captures 64-lane operands A/B/C,
// exec and VCC in one cycle, then presents them as four 16-lane beats,
// advancing one beat per src_shift_en.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   src_load_en               - capture wavefront inputs (when load_ready)
//   src_a/b/c_data            - 64-lane source operands
//   src_exec_value/vcc_value  - 64-lane exec mask / VCC
//   src_shift_en              - ALU consumed current beat
//   alu_src_a/b/c_data        - current 16-lane beat of each operand
//   alu_exec_mask, alu_vcc_in - current beat of exec / VCC
//   beat_valid, beat_count    - beat presented and its index
//   last_beat                 - presenting final beat
//   load_ready                - a load this cycle will be accepted
module src_shift_reg
  import src_shift_reg_pkg::*;
#(
  parameter int unsigned LANE_WIDTH = 32,
  parameter int unsigned NUM_BEATS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            src_load_en,
  input  logic [WF_LANES*LANE_WIDTH-1:0]  src_a_data,
  input  logic [WF_LANES*LANE_WIDTH-1:0]  src_b_data,
  input  logic [WF_LANES*LANE_WIDTH-1:0]  src_c_data,
  input  logic [WF_LANES-1:0]             src_exec_value,
  input  logic [WF_LANES-1:0]             src_vcc_value,
  input  logic                            src_shift_en,
  output logic [ALU_LANES*LANE_WIDTH-1:0] alu_src_a_data,
  output logic [ALU_LANES*LANE_WIDTH-1:0] alu_src_b_data,
  output logic [ALU_LANES*LANE_WIDTH-1:0] alu_src_c_data,
  output logic [ALU_LANES-1:0]            alu_exec_mask,
  output logic [ALU_LANES-1:0]            alu_vcc_in,
  output logic                            beat_valid,
  output logic [1:0]                      beat_count,
  output logic                            last_beat,
  output logic                            load_ready
);

  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  state_t     state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic       at_last;
  logic       load_acc;
  logic       shift_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // A load coinciding with the final shift wins, so the next wavefront's
  // beat 0 follows beat 3 with no bubble.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    at_last    = (state_q == SHIFT) && (beat_q == LAST_BEAT);
    load_ready = (state_q == IDLE) || (at_last && src_shift_en);
    load_acc   = src_load_en && load_ready;
    shift_acc  = (state_q == SHIFT) && src_shift_en;
    beat_valid = (state_q == SHIFT);
    beat_count = beat_q;
    last_beat  = at_last;
    if (load_acc) begin
      state_d = SHIFT;
      beat_d  = '0;
    end else if (shift_acc) begin
      if (at_last) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end
  end

  // After the fourth shift every register is all zero, which is what
  // keeps the data outputs at 0 in IDLE without an output mux.
  src_shift_reg_shift_in #(.LANE_WIDTH(LANE_WIDTH)) u_shift_a (
    .clk(clk), .rst(rst), .load_en(load_acc), .load_data(src_a_data),
    .shift_en(shift_acc), .beat_data(alu_src_a_data)
  );
  src_shift_reg_shift_in #(.LANE_WIDTH(LANE_WIDTH)) u_shift_b (
    .clk(clk), .rst(rst), .load_en(load_acc), .load_data(src_b_data),
    .shift_en(shift_acc), .beat_data(alu_src_b_data)
  );
  src_shift_reg_shift_in #(.LANE_WIDTH(LANE_WIDTH)) u_shift_c (
    .clk(clk), .rst(rst), .load_en(load_acc), .load_data(src_c_data),
    .shift_en(shift_acc), .beat_data(alu_src_c_data)
  );
  src_shift_reg_shift_in #(.LANE_WIDTH(1)) u_shift_exec (
    .clk(clk), .rst(rst), .load_en(load_acc), .load_data(src_exec_value),
    .shift_en(shift_acc), .beat_data(alu_exec_mask)
  );
  src_shift_reg_shift_in #(.LANE_WIDTH(1)) u_shift_vcc (
    .clk(clk), .rst(rst), .load_en(load_acc), .load_data(src_vcc_value),
    .shift_en(shift_acc), .beat_data(alu_vcc_in)
  );

endmodule

// File: tb/tb_src_shift_reg.sv
// Self-checking bench for src_shift_reg: each accepted load pushes the four
// expected beats onto a scoreboard; every cycle the presented beat is
// compared with the scoreboard head (or the all-zero idle beat).
module tb_src_shift_reg;

  logic          clk;
  logic          rst;
  logic          src_load_en;
  logic [2047:0] src_a_data, src_b_data, src_c_data;
  logic [63:0]   src_exec_value, src_vcc_value;
  logic          src_shift_en;
  logic [511:0]  alu_src_a_data, alu_src_b_data, alu_src_c_data;
  logic [15:0]   alu_exec_mask, alu_vcc_in;
  logic          beat_valid;
  logic [1:0]    beat_count;
  logic          last_beat;
  logic          load_ready;

  typedef struct packed {
    logic [511:0] a;
    logic [511:0] b;
    logic [511:0] c;
    logic [15:0]  ex;
    logic [15:0]  vc;
    logic [1:0]   cnt;
    logic         last;
    logic         valid;
  } beat_t;

  beat_t sb[$];
  int    passed = 0;
  int    total  = 0;

  src_shift_reg #(.LANE_WIDTH(32), .NUM_BEATS(4)) dut (
    .clk(clk), .rst(rst), .src_load_en(src_load_en),
    .src_a_data(src_a_data), .src_b_data(src_b_data), .src_c_data(src_c_data),
    .src_exec_value(src_exec_value), .src_vcc_value(src_vcc_value),
    .src_shift_en(src_shift_en),
    .alu_src_a_data(alu_src_a_data), .alu_src_b_data(alu_src_b_data),
    .alu_src_c_data(alu_src_c_data), .alu_exec_mask(alu_exec_mask),
    .alu_vcc_in(alu_vcc_in), .beat_valid(beat_valid), .beat_count(beat_count),
    .last_beat(last_beat), .load_ready(load_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2047:0] lanes(input logic [31:0] base);
    logic [2047:0] v;
    for (int i = 0; i < 64; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  function automatic logic [2047:0] rand_vec();
    logic [2047:0] v;
    for (int i = 0; i < 64; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic beat_t sample();
    beat_t s;
    s.a = alu_src_a_data;  s.b = alu_src_b_data;  s.c = alu_src_c_data;
    s.ex = alu_exec_mask;  s.vc = alu_vcc_in;
    s.cnt = beat_count;    s.last = last_beat;    s.valid = beat_valid;
    return s;
  endfunction

  function automatic beat_t head();
    beat_t e;
    e = '0;
    if (sb.size() != 0) e = sb[0];
    return e;
  endfunction

  // Reference model of the coming clock edge, driven purely by bench inputs.
  task automatic update_model();
    bit    ready;
    beat_t e;
    if (rst) begin
      sb.delete();
      return;
    end
    ready = (sb.size() == 0) || (sb[0].last && src_shift_en);
    if (sb.size() != 0 && src_shift_en) void'(sb.pop_front());
    if (src_load_en && ready) begin
      for (int b = 0; b < 4; b++) begin
        e.a = src_a_data[512*b +: 512];
        e.b = src_b_data[512*b +: 512];
        e.c = src_c_data[512*b +: 512];
        e.ex = src_exec_value[16*b +: 16];
        e.vc = src_vcc_value[16*b +: 16];
        e.cnt = 2'(b);
        e.last = (b == 3);
        e.valid = 1'b1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic step();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic new_wavefront(input logic [31:0] a_base, input logic [63:0] ex);
    src_a_data = lanes(a_base);
    src_b_data = rand_vec();
    src_c_data = rand_vec();
    src_exec_value = ex;
    src_vcc_value = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    beat_t o;
    rst = 1'b1;
    step();
    @(negedge clk);
    o = sample();
    total++;
    if (o !== '0 || load_ready !== 1'b1)
      $display("FAIL reset: valid=%0b cnt=%0d a0=%h ready=%0b, expected all 0 and ready=1",
               o.valid, o.cnt, o.a[31:0], load_ready);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_wavefront();
    beat_t o, e;
    new_wavefront(32'hA000_0000, 64'hFFFF_0000_FFFF_0000);
    src_load_en = 1'b1;
    src_shift_en = 1'b0;
    @(negedge clk);
    total++;
    if (load_ready !== 1'b1) $display("FAIL single_ready: got %0b, expected 1", load_ready);
    else passed++;
    step();
    src_load_en = 1'b0;
    src_shift_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o = sample();
      e = head();
      total++;
      if (o !== e)
        $display("FAIL single_beat%0d: got cnt=%0d v=%0b l=%0b a0=%h ex=%h, expected cnt=%0d v=%0b l=%0b a0=%h ex=%h",
                 i, o.cnt, o.valid, o.last, o.a[31:0], o.ex, e.cnt, e.valid, e.last, e.a[31:0], e.ex);
      else passed++;
      if (i == 1) begin
        total++;
        if (alu_src_a_data[31:0] !== 32'hA000_0010 || alu_exec_mask !== 16'hFFFF)
          $display("FAIL single_beat1_lane16: got a=%h ex=%h, expected a=a0000010 ex=ffff",
                   alu_src_a_data[31:0], alu_exec_mask);
        else passed++;
      end
      if (i == 3) begin
        total++;
        if (last_beat !== 1'b1 || alu_src_a_data[511:480] !== 32'hA000_003F)
          $display("FAIL single_beat3_last: got last=%0b a15=%h, expected last=1 a15=a000003f",
                   last_beat, alu_src_a_data[511:480]);
        else passed++;
      end
      step();
    end
    src_shift_en = 1'b0;
  endtask

  task automatic test_stall();
    beat_t o, e;
    new_wavefront(32'h3000_0000, {$urandom, $urandom});
    src_load_en = 1'b1;
    step();
    src_load_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src_shift_en = (i == 0) || (i >= 6);
      @(negedge clk);
      o = sample();
      e = head();
      total++;
      if (o !== e)
        $display("FAIL stall_cycle%0d: got cnt=%0d v=%0b a0=%h, expected cnt=%0d v=%0b a0=%h",
                 i, o.cnt, o.valid, o.a[31:0], e.cnt, e.valid, e.a[31:0]);
      else passed++;
      if (i == 5) begin
        total++;
        if (beat_count !== 2'd1 || alu_src_a_data[31:0] !== 32'h3000_0010)
          $display("FAIL stall_hold: got cnt=%0d a0=%h, expected cnt=1 a0=30000010",
                   beat_count, alu_src_a_data[31:0]);
        else passed++;
      end
      step();
    end
    src_shift_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    beat_t o, e;
    new_wavefront(32'h5000_0000, {$urandom, $urandom});
    src_load_en = 1'b1;
    src_shift_en = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      src_shift_en = 1'b1;
      src_load_en = (i == 3);
      if (i == 3) begin
        new_wavefront(32'h6000_0000, {$urandom, $urandom});
        src_b_data = lanes(32'hB000_0000);
      end
      @(negedge clk);
      o = sample();
      e = head();
      total++;
      if (o !== e)
        $display("FAIL b2b_cycle%0d: got cnt=%0d v=%0b a0=%h b0=%h, expected cnt=%0d v=%0b a0=%h b0=%h",
                 i, o.cnt, o.valid, o.a[31:0], o.b[31:0], e.cnt, e.valid, e.a[31:0], e.b[31:0]);
      else passed++;
      if (i == 3) begin
        total++;
        if (load_ready !== 1'b1) $display("FAIL b2b_ready: got %0b, expected 1", load_ready);
        else passed++;
      end
      if (i == 4) begin
        total++;
        if (beat_valid !== 1'b1 || beat_count !== 2'd0 || alu_src_b_data[31:0] !== 32'hB000_0000)
          $display("FAIL b2b_new_beat0: got v=%0b cnt=%0d b0=%h, expected v=1 cnt=0 b0=b0000000",
                   beat_valid, beat_count, alu_src_b_data[31:0]);
        else passed++;
      end
      step();
    end
    src_load_en = 1'b0;
    src_shift_en = 1'b0;
  endtask

  task automatic test_illegal_load();
    beat_t o, e;
    new_wavefront(32'h7000_0000, {$urandom, $urandom});
    src_load_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      src_shift_en = 1'b1;
      src_load_en = (i == 1) || (i == 2);
      if (i == 1) new_wavefront(32'h8000_0000, {$urandom, $urandom});
      @(negedge clk);
      o = sample();
      e = head();
      total++;
      if (o !== e)
        $display("FAIL illegal_cycle%0d: got cnt=%0d v=%0b a0=%h, expected cnt=%0d v=%0b a0=%h",
                 i, o.cnt, o.valid, o.a[31:0], e.cnt, e.valid, e.a[31:0]);
      else passed++;
      if (src_load_en) begin
        total++;
        if (load_ready !== 1'b0) $display("FAIL illegal_ready%0d: got %0b, expected 0", i, load_ready);
        else passed++;
      end
      step();
    end
    src_load_en = 1'b0;
    src_shift_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    beat_t o, e;
    new_wavefront(32'h9000_0000, {$urandom, $urandom});
    src_load_en = 1'b1;
    step();
    src_load_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_shift_en = (i < 2);
      rst = (i == 2);
      @(negedge clk);
      o = sample();
      e = head();
      total++;
      if (o !== e)
        $display("FAIL rstmid_cycle%0d: got cnt=%0d v=%0b a0=%h, expected cnt=%0d v=%0b a0=%h",
                 i, o.cnt, o.valid, o.a[31:0], e.cnt, e.valid, e.a[31:0]);
      else passed++;
      step();
    end
    rst = 1'b0;
    src_shift_en = 1'b0;
    @(negedge clk);
    o = sample();
    total++;
    if (o !== '0 || load_ready !== 1'b1)
      $display("FAIL rstmid_idle: got v=%0b cnt=%0d a0=%h ready=%0b, expected all 0 and ready=1",
               o.valid, o.cnt, o.a[31:0], load_ready);
    else passed++;
    new_wavefront(32'hC000_0000, {$urandom, $urandom});
    src_load_en = 1'b1;
    step();
    src_load_en = 1'b0;
    src_shift_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o = sample();
      e = head();
      total++;
      if (o !== e)
        $display("FAIL rstmid_reload%0d: got cnt=%0d v=%0b a0=%h, expected cnt=%0d v=%0b a0=%h",
                 i, o.cnt, o.valid, o.a[31:0], e.cnt, e.valid, e.a[31:0]);
      else passed++;
      step();
    end
    src_shift_en = 1'b0;
  endtask

  task automatic test_idle_shift();
    beat_t o;
    src_load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_shift_en = (i % 2 == 0);
      @(negedge clk);
      o = sample();
      total++;
      if (o !== '0)
        $display("FAIL idle_shift%0d: got v=%0b cnt=%0d a0=%h, expected v=0 cnt=0 a0=0",
                 i, o.valid, o.cnt, o.a[31:0]);
      else passed++;
      step();
    end
    src_shift_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src_load_en = 1'b0;
    src_shift_en = 1'b0;
    src_a_data = '0;
    src_b_data = '0;
    src_c_data = '0;
    src_exec_value = '0;
    src_vcc_value = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_idle_shift();
    test_single_wavefront();
    test_stall();
    test_back_to_back();
    test_illegal_load();
    test_reset_mid();
    test_idle_shift();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
